// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access widths, FSM states
// and the latency counter width.
package dmem_pkg;

   localparam logic [1:0] WIDTH_BYTE = 2'b00;
   localparam logic [1:0] WIDTH_HALF = 2'b01;
   localparam logic [1:0] WIDTH_WORD = 2'b10;

   localparam int LAT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      RESP = 2'b10
   } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte-enables and data replication for the
// incoming request, and lane extraction with sign/zero extension for loads.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  st_lo,
   input  logic [1:0]  st_width,
   input  logic [31:0] st_wdata,
   output logic [3:0]  st_be,
   output logic [31:0] st_lanes,
   input  logic [1:0]  ld_lo,
   input  logic [1:0]  ld_width,
   input  logic        ld_sign,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [31:0] shifted;

   // Replicating the data across lanes lets the byte-enables alone pick the target.
   always_comb begin
      st_be    = 4'b0000;
      st_lanes = st_wdata;
      case (st_width)
         WIDTH_BYTE: begin
            st_be    = 4'b0001 << st_lo;
            st_lanes = {4{st_wdata[7:0]}};
         end
         WIDTH_HALF: begin
            st_be    = st_lo[1] ? 4'b1100 : 4'b0011;
            st_lanes = {2{st_wdata[15:0]}};
         end
         WIDTH_WORD: st_be = 4'b1111;
         default: ;
      endcase
   end

   always_comb begin
      shifted = ld_word >> {ld_lo, 3'b000};
      ld_data = shifted;
      case (ld_width)
         WIDTH_BYTE: ld_data = {{24{ld_sign & shifted[7]}}, shifted[7:0]};
         WIDTH_HALF: ld_data = {{16{ld_sign & shifted[15]}}, shifted[15:0]};
         default:    ld_data = shifted;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory slave: one outstanding request, fixed latency response.
// Optional misalignment errors are enabled with the DMEM_ALIGN_CHECK_EN macro.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
)(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [1:0]  req_width_i,
   input  logic        req_sign_extend_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o
);

   localparam int          IDX_W      = $clog2(DEPTH_WORDS);
   localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);

   state_t            state_reg, state_next;
   logic [LAT_W-1:0]  cnt_reg, cnt_next;
   logic [31:0]       mem [DEPTH_WORDS];
   logic [31:0]       rd_word_reg;
   logic [1:0]        ld_lo_reg, ld_width_reg;
   logic              ld_sign_reg, err_reg, load_ok_reg;

   logic              accept, req_err, misalign;
   logic [1:0]        eff_lo;
   logic [IDX_W-1:0]  idx;
   logic [3:0]        st_be;
   logic [31:0]       st_lanes, ld_data;

   assign accept = req_valid_i & req_ready_o;
   assign idx    = req_addr_i[IDX_W+1:2];

   always_comb begin
      misalign = 1'b0;
      eff_lo   = req_addr_i[1:0];
`ifdef DMEM_ALIGN_CHECK_EN
      if (req_width_i == WIDTH_HALF)      misalign = req_addr_i[0];
      else if (req_width_i == WIDTH_WORD) misalign = |req_addr_i[1:0];
`else
      if (req_width_i == WIDTH_HALF)      eff_lo = {req_addr_i[1], 1'b0};
      else if (req_width_i == WIDTH_WORD) eff_lo = 2'b00;
`endif
   end

   // Full-width compare so addresses beyond the array never alias into it.
   assign req_err = ({1'b0, req_addr_i} >= ADDR_LIMIT) || (req_width_i == 2'b11) || misalign;

   dmem_lane_align u_lane_align (
      .st_lo    (eff_lo),
      .st_width (req_width_i),
      .st_wdata (req_wdata_i),
      .st_be    (st_be),
      .st_lanes (st_lanes),
      .ld_lo    (ld_lo_reg),
      .ld_width (ld_width_reg),
      .ld_sign  (ld_sign_reg),
      .ld_word  (rd_word_reg),
      .ld_data  (ld_data)
   );

   always_ff @(posedge clk_i) begin
      if (accept && !req_err) begin
         if (req_write_i) begin
            for (int i = 0; i < 4; i++)
               if (st_be[i]) mem[idx][8*i +: 8] <= st_lanes[8*i +: 8];
         end else begin
            rd_word_reg <= mem[idx];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         err_reg      <= 1'b0;
         load_ok_reg  <= 1'b0;
         ld_lo_reg    <= 2'b00;
         ld_width_reg <= 2'b00;
         ld_sign_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (accept) begin
            err_reg      <= req_err;
            load_ok_reg  <= !req_write_i && !req_err;
            ld_lo_reg    <= eff_lo;
            ld_width_reg <= req_width_i;
            ld_sign_reg  <= req_sign_extend_i;
         end
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      req_ready_o  = 1'b0;
      resp_valid_o = 1'b0;
      case (state_reg)
         IDLE: begin
            req_ready_o = 1'b1;
            if (req_valid_i) begin
               if (LATENCY == 1) begin
                  state_next = RESP;
               end else begin
                  state_next = WAIT;
                  cnt_next   = LAT_W'(LATENCY - 2);
               end
            end
         end
         WAIT: begin
            if (cnt_reg == '0) state_next = RESP;
            else               cnt_next   = cnt_reg - 1'b1;
         end
         RESP: begin
            resp_valid_o = 1'b1;
            if (resp_ready_i) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign resp_rdata_o = (state_reg == RESP && load_ok_reg) ? ld_data : 32'h0;
   assign resp_err_o   = (state_reg == RESP) && err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed steps plus randomized
// traffic against a byte-array reference model.
module tb_dmem_responder;

   localparam int DEPTH = 256;
   localparam int LAT   = 2;

   logic        clk = 1'b0;
   logic        rst_n, rst4_n;
   logic        req_valid, req_valid4, req_write, req_sign, resp_ready;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_width;
   logic        req_ready, resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        req_ready4, resp_valid4, resp_err4;
   logic [31:0] resp_rdata4;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] mdl [0:4*DEPTH-1];

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
      .clk_i(clk), .rst_i(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_width_i(req_width),
      .req_sign_extend_i(req_sign),
      .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
      .resp_rdata_o(resp_rdata), .resp_err_o(resp_err)
   );

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(4)) u_dut4 (
      .clk_i(clk), .rst_i(rst4_n),
      .req_valid_i(req_valid4), .req_ready_o(req_ready4), .req_write_i(1'b0),
      .req_addr_i(32'h10), .req_wdata_i(32'h0), .req_width_i(2'b10),
      .req_sign_extend_i(1'b0),
      .resp_valid_o(resp_valid4), .resp_ready_i(1'b1),
      .resp_rdata_o(resp_rdata4), .resp_err_o(resp_err4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: effective byte address, error rules, little-endian byte array.
   task automatic model(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] wid, input logic sx,
                        output logic [31:0] rd, output logic er);
      int n;
      logic [31:0] ea;
      er = 1'b0;
      rd = 32'h0;
      n  = 1 << wid;
      ea = a;
      if (wid == 2'b11 || a >= 32'(4 * DEPTH)) er = 1'b1;
      if (!er) begin
`ifdef DMEM_ALIGN_CHECK_EN
         if (a % n != 0) er = 1'b1;
`else
         ea = a - (a % n);
`endif
      end
      if (er) return;
      if (w) begin
         for (int i = 0; i < n; i++) mdl[ea + i] = wd[8*i +: 8];
      end else begin
         for (int i = 0; i < n; i++) rd[8*i +: 8] = mdl[ea + i];
         if (sx && n < 4 && rd[8*n-1]) rd = rd | ~((32'd1 << (8*n)) - 1);
      end
   endtask

   // One transaction: accept, measure latency, hold off resp_ready, handshake.
   task automatic xact(input string tag, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] wid, input logic sx,
                       input int hold, input logic [31:0] exp_rd, input logic exp_er);
      int lat;
      logic [31:0] rd0;
      logic er0;
      logic [31:0] mrd;
      logic mer;
      model(w, a, wd, wid, sx, mrd, mer);
      @(negedge clk);
      chk({tag, "_ready_before"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
      req_width = wid; req_sign = sx; resp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_addr  = $urandom; req_wdata = $urandom;
      lat = 0;
      while (!resp_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat + 1), 32'(LAT));
      chk({tag, "_rdata"}, resp_rdata, exp_rd);
      chk({tag, "_err"}, 32'(resp_err), 32'(exp_er));
      rd0 = resp_rdata; er0 = resp_err;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
         chk({tag, "_hold_rdata"}, resp_rdata, rd0);
         chk({tag, "_hold_err"}, 32'(resp_err), 32'(er0));
         chk({tag, "_hold_ready"}, 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk({tag, "_valid_after"}, 32'(resp_valid), 32'd0);
      chk({tag, "_ready_after"}, 32'(req_ready), 32'd1);
      $display("xact %s w=%0d addr=%h width=%0d sx=%0d rdata=%h err=%0d lat=%0d",
               tag, w, a, wid, sx, rd0, er0, lat + 1);
   endtask

   // Random transaction checked against the model's prediction.
   task automatic rxact(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [1:0] wid, input logic sx,
                        input int hold);
      logic [31:0] mrd;
      logic mer;
      logic [7:0] snap [0:4*DEPTH-1];
      snap = mdl;
      model(w, a, wd, wid, sx, mrd, mer);
      mdl = snap;
      xact(tag, w, a, wd, wid, sx, hold, mrd, mer);
   endtask

   initial begin
      logic [31:0] exp_half;
      logic        exp_half_err;
      rst_n = 1'b0; rst4_n = 1'b0;
      req_valid = 1'b0; req_valid4 = 1'b0; req_write = 1'b0; req_sign = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0; req_width = 2'b10; resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready", 32'(req_ready), 32'd1);
      chk("reset_valid", 32'(resp_valid), 32'd0);
      chk("reset_rdata", resp_rdata, 32'h0);
      chk("reset_err", 32'(resp_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1; rst4_n = 1'b1;

      // Reset mid-WAIT on the LATENCY=4 instance.
      @(negedge clk);
      chk("rst4_ready_before", 32'(req_ready4), 32'd1);
      req_valid4 = 1'b1;
      @(posedge clk); #1;
      req_valid4 = 1'b0;
      chk("rst4_in_wait", 32'(req_ready4), 32'd0);
      @(posedge clk); #1;
      rst4_n = 1'b0;
      #1;
      chk("rst4_valid_async", 32'(resp_valid4), 32'd0);
      chk("rst4_ready_async", 32'(req_ready4), 32'd1);
      @(negedge clk);
      rst4_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("rst4_no_stale", 32'(resp_valid4), 32'd0);
      end
      $display("xact reset_mid_wait done");

      // Fill the array so every later load has a defined model value.
      for (int i = 0; i < DEPTH; i++)
         rxact("init", 1'b1, 32'(4*i), $urandom, 2'b10, 1'b0, 0);

      xact("st_word",   1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 0, 32'h0, 1'b0);
      xact("ld_word",   1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 0, 32'hDEADBEEF, 1'b0);
      xact("st_byte",   1'b1, 32'h11, 32'h80,       2'b00, 1'b0, 0, 32'h0, 1'b0);
      xact("ld_byte_s", 1'b0, 32'h11, 32'h0,        2'b00, 1'b1, 0, 32'hFFFFFF80, 1'b0);
      xact("ld_byte_u", 1'b0, 32'h11, 32'h0,        2'b00, 1'b0, 0, 32'h00000080, 1'b0);
      xact("ld_word2",  1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 0, 32'hDEAD80EF, 1'b0);
      xact("ld_half_s", 1'b0, 32'h12, 32'h0,        2'b01, 1'b1, 5, 32'hFFFFDEAD, 1'b0);
      xact("st_oor",    1'b1, 32'h400, 32'h12345678, 2'b10, 1'b0, 0, 32'h0, 1'b1);
      xact("ld_rsvd",   1'b0, 32'h10, 32'h0,        2'b11, 1'b0, 0, 32'h0, 1'b1);
      xact("ld_word3",  1'b0, 32'h10, 32'h0,        2'b10, 1'b0, 0, 32'hDEAD80EF, 1'b0);
      xact("ld_last",   1'b0, 32'h3FC, 32'h0,       2'b10, 1'b0, 0, {mdl[1023], mdl[1022], mdl[1021], mdl[1020]}, 1'b0);
      xact("ld_huge",   1'b0, 32'h8000_0010, 32'h0, 2'b10, 1'b0, 0, 32'h0, 1'b1);
`ifdef DMEM_ALIGN_CHECK_EN
      exp_half = 32'h0; exp_half_err = 1'b1;
`else
      exp_half = 32'h0000DEAD; exp_half_err = 1'b0;
`endif
      xact("ld_half_mis", 1'b0, 32'h13, 32'h0, 2'b01, 1'b0, 0, exp_half, exp_half_err);

      for (int i = 0; i < 300; i++)
         rxact("rand", 1'($urandom_range(0, 1)), 32'($urandom_range(0, 1100)), $urandom,
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 2));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
